// File: rtl/imm_pipe_pkg.sv
// imm_pkg: opcodes, immediate format codes and the decoded-entry struct
// shared by the immediate pipeline.
// Optional build macro IMM_PIPE_CSR_EN enables the CSR zimm (Z) format.
package imm_pkg;

    // Widest supported datapath; entries are sized for it and trimmed to XLEN.
    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

`ifdef IMM_PIPE_CSR_EN
    localparam bit CSR_EN = 1'b1;
`else
    localparam bit CSR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        I = 3'd0,
        S = 3'd1,
        B = 3'd2,
        J = 3'd3,
        U = 3'd4,
        Z = 3'd5
    } imm_fmt_e;

    // Bits above XLEN are always zero.
    typedef struct packed {
        logic [XLEN_MAX-1:0] simm;
        logic [XLEN_MAX-1:0] uimm;
        imm_fmt_e            fmt;
    } imm_res_t;

    // Format selection from the opcode; funct3[2] distinguishes CSR immediates.
    function automatic imm_fmt_e fmt_of(input logic [6:0] opcode,
                                        input logic       funct3_msb);
        imm_fmt_e f;
        case (opcode)
            OPC_STORE:          f = S;
            OPC_BRANCH:         f = B;
            OPC_JAL:            f = J;
            OPC_LUI, OPC_AUIPC: f = U;
            OPC_SYSTEM:         f = (CSR_EN && funct3_msb) ? Z : I;
            default:            f = I;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_pipe_if.sv
// imm_pipe_if: input instruction stream and output immediate stream.
// The slave modport is the pipeline's view; master is the fetch/execute side.
interface imm_pipe_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] insn;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] simm;
    logic [XLEN-1:0] uimm;
    logic [2:0]      fmt;

    modport master (
        output in_valid, insn, out_ready,
        input  in_ready, out_valid, simm, uimm, fmt
    );

    modport slave (
        input  in_valid, insn, out_ready,
        output in_ready, out_valid, simm, uimm, fmt
    );
endinterface

// File: rtl/imm_pipe_decode.sv
// imm_decode: combinational RISC-V immediate generator feeding the buffer.
// Honours IMM_PIPE_CSR_EN through imm_pkg::fmt_of (Z format for CSR zimm).
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] insn,
    output imm_res_t    res
);

    imm_fmt_e    fmt;
    logic [31:0] imm_s;   // field sign-extended to 32 bits
    logic [31:0] imm_u;   // field zero-extended to 32 bits

    // Assemble the raw immediate field for the decoded format.
    always_comb begin
        fmt   = fmt_of(insn[6:0], insn[14]);
        imm_s = '0;
        imm_u = '0;
        case (fmt)
            S: begin
                imm_u = {20'b0, insn[31:25], insn[11:7]};
                imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            end
            B: begin
                imm_u = {19'b0, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
                imm_s = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            end
            J: begin
                imm_u = {11'b0, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                imm_s = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            end
            U: begin
                imm_u = {insn[31:12], 12'b0};
                imm_s = {insn[31:12], 12'b0};
            end
            Z: begin
                imm_u = {27'b0, insn[19:15]};
                imm_s = {27'b0, insn[19:15]};
            end
            default: begin
                imm_u = {20'b0, insn[31:20]};
                imm_s = {{20{insn[31]}}, insn[31:20]};
            end
        endcase
    end

    // Extend to XLEN (U sign-extends from bit 31, RV64 LUI semantics).
    always_comb begin
        res                = '0;
        res.simm[XLEN-1:0] = XLEN'($signed(imm_s));
        res.uimm[XLEN-1:0] = XLEN'(imm_u);
        res.fmt            = fmt;
    end

endmodule

// File: rtl/imm_pipe.sv
// imm_pipe: pipelined immediate generator with a two-entry elastic buffer
// (OUT register plus SKID register) and a flush for redirects.
// Build macro IMM_PIPE_CSR_EN enables the Z (CSR zimm) format in the decoder.
module imm_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic      clk,
    input  logic      xreset,
    input  logic      flush,
    imm_pipe_if.slave bus
);

    if (ILEN != 32) begin : g_bad_ilen
        $error("imm_pipe: ILEN must be 32");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_pipe: XLEN must be 32 or 64");
    end

    imm_res_t dec_res;
    imm_res_t out_q;
    imm_res_t skid_q;
    logic     out_v;
    logic     skid_v;
    logic     in_rdy;
    logic     in_fire;
    logic     out_fire;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .insn (bus.insn),
        .res  (dec_res)
    );

    // Accept only while SKID is free; flush and reset block same-cycle input.
    assign in_rdy   = !skid_v && !flush && !xreset;
    assign in_fire  = bus.in_valid && in_rdy;
    assign out_fire = out_v && bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_v;
    assign bus.simm      = out_q.simm[XLEN-1:0];
    assign bus.uimm      = out_q.uimm[XLEN-1:0];
    assign bus.fmt       = out_q.fmt;

    if (XLEN < XLEN_MAX) begin : g_trim
        logic unused_hi;
        assign unused_hi = ^{out_q.simm[XLEN_MAX-1:XLEN], out_q.uimm[XLEN_MAX-1:XLEN]};
    end

    // Elastic buffer: refill OUT from SKID first, else from the decoder;
    // park the input in SKID when OUT is held. SKID is never loaded while
    // it drains because in_ready is low whenever SKID is occupied.
    always_ff @(posedge clk) begin
        if (xreset) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (out_fire || !out_v) begin
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                out_v <= in_fire;
                if (in_fire) begin
                    out_q <= dec_res;
                end
            end
        end else if (in_fire) begin
            skid_q <= dec_res;
            skid_v <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_pipe.sv
// Directed self-checking bench for imm_pipe at XLEN=32 and XLEN=64.
// Both instances receive the same stream; define IMM_PIPE_CSR_EN to match the RTL build.
module tb_imm_pipe;

    logic clk;
    logic xreset;
    logic flush;

    int unsigned total;
    int unsigned bad;

    imm_pipe_if #(.XLEN(32), .ILEN(32)) b32 ();
    imm_pipe_if #(.XLEN(64), .ILEN(32)) b64 ();

    imm_pipe #(.XLEN(32), .ILEN(32)) u_dut32 (
        .clk    (clk),
        .xreset (xreset),
        .flush  (flush),
        .bus    (b32)
    );

    imm_pipe #(.XLEN(64), .ILEN(32)) u_dut64 (
        .clk    (clk),
        .xreset (xreset),
        .flush  (flush),
        .bus    (b64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] s32;
        logic [31:0] u32;
        logic [63:0] s64;
        logic [2:0]  fmt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] word);
        b32.in_valid = v;
        b32.insn     = word;
        b64.in_valid = v;
        b64.insn     = word;
    endtask

    task automatic set_ordy(input logic r);
        b32.out_ready = r;
        b64.out_ready = r;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 32'h00000FFF, 64'hFFFFFFFF_FFFFFFFF, 3'd0};
        vecs[1] = '{32'hFE112E23, 32'hFFFFFFFC, 32'h00000FFC, 64'hFFFFFFFF_FFFFFFFC, 3'd1};
        vecs[2] = '{32'hFE000CE3, 32'hFFFFFFF8, 32'h00001FF8, 64'hFFFFFFFF_FFFFFFF8, 3'd2};
        vecs[3] = '{32'hFFDFF06F, 32'hFFFFFFFC, 32'h001FFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3};
        vecs[4] = '{32'h800000B7, 32'h80000000, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4};
        vecs[5] = '{32'h12345017, 32'h12345000, 32'h12345000, 64'h00000000_12345000, 3'd4};
`ifdef IMM_PIPE_CSR_EN
        vecs[6] = '{32'h3002D073, 32'h00000005, 32'h00000005, 64'h00000000_00000005, 3'd5};
`else
        vecs[6] = '{32'h3002D073, 32'h00000300, 32'h00000300, 64'h00000000_00000300, 3'd0};
`endif

        // Reset state
        xreset = 1'b1;
        flush  = 1'b0;
        drive(1'b0, 32'h0);
        set_ordy(1'b1);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(b32.in_ready), 64'd0);
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_simm", 64'(b32.simm), 64'd0);
        chk("rst_uimm", 64'(b32.uimm), 64'd0);
        chk("rst_fmt", 64'(b32.fmt), 64'd0);
        xreset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(b32.in_ready), 64'd1);

        // Back-to-back stream, one result per cycle
        drive(1'b1, vecs[0].insn);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", k), 64'(b32.out_valid), 64'd1);
            chk($sformatf("v%0d_in_ready", k), 64'(b32.in_ready), 64'd1);
            chk($sformatf("v%0d_simm32", k), 64'(b32.simm), 64'(vecs[k].s32));
            chk($sformatf("v%0d_uimm32", k), 64'(b32.uimm), 64'(vecs[k].u32));
            chk($sformatf("v%0d_fmt", k), 64'(b32.fmt), 64'(vecs[k].fmt));
            chk($sformatf("v%0d_simm64", k), b64.simm, vecs[k].s64);
            chk($sformatf("v%0d_uimm64", k), b64.uimm, 64'(vecs[k].u32));
            chk($sformatf("v%0d_fmt64", k), 64'(b64.fmt), 64'(vecs[k].fmt));
            if (k < 6) drive(1'b1, vecs[k+1].insn);
            else       drive(1'b0, 32'h0);
        end
        @(negedge clk);
        chk("stream_drained", 64'(b32.out_valid), 64'd0);

        // Backpressure: A in OUT, B in SKID, C held off
        set_ordy(1'b0);
        drive(1'b1, 32'h123450B7);
        @(negedge clk);
        chk("bp_a_valid", 64'(b32.out_valid), 64'd1);
        chk("bp_a_simm", 64'(b32.simm), 64'h12345000);
        chk("bp_a_in_ready", 64'(b32.in_ready), 64'd1);
        drive(1'b1, 32'h00100093);
        @(negedge clk);
        chk("bp_full_in_ready", 64'(b32.in_ready), 64'd0);
        chk("bp_hold_simm", 64'(b32.simm), 64'h12345000);
        drive(1'b1, 32'hFE112E23);
        @(negedge clk);
        chk("bp_c_blocked_ready", 64'(b32.in_ready), 64'd0);
        chk("bp_stable_simm", 64'(b32.simm), 64'h12345000);
        chk("bp_stable_fmt", 64'(b32.fmt), 64'd4);
        set_ordy(1'b1);
        #1;
        chk("bp_drain_full_ready", 64'(b32.in_ready), 64'd0);
        @(negedge clk);
        chk("bp_b_valid", 64'(b32.out_valid), 64'd1);
        chk("bp_b_simm", 64'(b32.simm), 64'd1);
        chk("bp_b_fmt", 64'(b32.fmt), 64'd0);
        chk("bp_b_in_ready", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h0);
        chk("bp_c_valid", 64'(b32.out_valid), 64'd1);
        chk("bp_c_simm", 64'(b32.simm), 64'hFFFFFFFC);
        chk("bp_c_fmt", 64'(b32.fmt), 64'd1);
        @(negedge clk);
        chk("bp_empty", 64'(b32.out_valid), 64'd0);

        // Flush while full with a same-cycle input
        set_ordy(1'b0);
        drive(1'b1, 32'h123450B7);
        @(negedge clk);
        drive(1'b1, 32'h00100093);
        @(negedge clk);
        chk("fl_full_ready", 64'(b32.in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00200093);
        #1;
        chk("fl_in_ready", 64'(b32.in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("fl_out_valid", 64'(b32.out_valid), 64'd0);
        #1;
        chk("fl_ready_after", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        chk("fl_not_accepted", 64'(b32.out_valid), 64'd0);

        // Reset mid-stream
        set_ordy(1'b0);
        drive(1'b1, 32'h123450B7);
        @(negedge clk);
        chk("rs_pre_valid", 64'(b32.out_valid), 64'd1);
        xreset = 1'b1;
        drive(1'b1, 32'h00100093);
        @(negedge clk);
        chk("rs_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rs_simm", 64'(b32.simm), 64'd0);
        chk("rs_uimm", 64'(b32.uimm), 64'd0);
        chk("rs_fmt", 64'(b32.fmt), 64'd0);
        chk("rs_simm64", b64.simm, 64'd0);
        chk("rs_in_ready", 64'(b32.in_ready), 64'd0);
        xreset = 1'b0;
        drive(1'b0, 32'h0);
        @(negedge clk);
        chk("rs_after_valid", 64'(b32.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
